// File: rtl/filter2d_seq.sv
// Job sequencer for filter2d: replays shadow coefficients, launches nframes runs, owns the buffer port mux.
// Latency: go to first f_start is NCOEF+1 cycles; f_finish to done is 1 cycle (done is decoded from state).
// Backpressure: none; go while busy and coefficient writes outside IDLE are dropped, host memory access is cut off while the engine owns the buffer.
//
// Ports: clk/rst (sync, active-high); hcfg_* host coefficient writes; go/nframes job start;
// busy/done/err status; hm_* host buffer port; h_* coefficient replay and f_start/f_finish to filter2d;
// f_* engine buffer port; m_* single-port buffer.
// Optional feature: define FSEQ_WATCHDOG_EN to add a RUN-state watchdog that sets err and aborts the job.
module filter2d_seq #(
  parameter int NCOEF   = 9,
  parameter int IDXW    = 4,
  parameter int DW      = 8,
  parameter int AW      = 17,
  parameter int FRAME_W = 8,
  parameter int TO_W    = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hcfg_we,
  input  logic [IDXW-1:0]    hcfg_idx,
  input  logic [DW-1:0]      hcfg_data,
  input  logic               go,
  input  logic [FRAME_W-1:0] nframes,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic               hm_cs,
  input  logic               hm_we,
  input  logic [AW-1:0]      hm_addr,
  input  logic [DW-1:0]      hm_wdata,
  output logic [DW-1:0]      hm_rdata,
  output logic               h_write,
  output logic [IDXW-1:0]    h_idx,
  output logic [DW-1:0]      h_data,
  output logic               f_start,
  input  logic               f_finish,
  input  logic               f_cs,
  input  logic               f_we,
  input  logic [AW-1:0]      f_addr,
  input  logic [DW-1:0]      f_wdata,
  output logic [DW-1:0]      f_rdata,
  output logic               m_cs,
  output logic               m_we,
  output logic [AW-1:0]      m_addr,
  output logic [DW-1:0]      m_din,
  input  logic [DW-1:0]      m_dout
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_NEXT} state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCOEF - 1);
  localparam logic [IDXW-1:0] NCOEF_I  = IDXW'(NCOEF);
  localparam logic            OWN_HOST = 1'b0;
  localparam logic            OWN_ENG  = 1'b1;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic [IDXW-1:0]    k_q, k_d;
  logic [FRAME_W-1:0] frames_q, frames_d;
  logic [DW-1:0]      shadow_q [NCOEF];
  logic [DW-1:0]      shadow_d [NCOEF];

`ifdef FSEQ_WATCHDOG_EN
  logic               err_q, err_d;
  logic [TO_W-1:0]    wd_q, wd_d;
  assign err = err_q;
`else
  localparam int unused_to_w = TO_W;
  assign err = 1'b0;
`endif

  assign busy = (state_q != S_IDLE);

  // Buffer mux keys off the registered owner bit only, so the port never glitches mid-cycle.
  assign m_cs     = (owner_q == OWN_ENG) ? f_cs    : hm_cs;
  assign m_we     = (owner_q == OWN_ENG) ? f_we    : hm_we;
  assign m_addr   = (owner_q == OWN_ENG) ? f_addr  : hm_addr;
  assign m_din    = (owner_q == OWN_ENG) ? f_wdata : hm_wdata;
  assign hm_rdata = (owner_q == OWN_ENG) ? '0      : m_dout;
  assign f_rdata  = (owner_q == OWN_ENG) ? m_dout  : '0;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    k_d      = k_q;
    frames_d = frames_q;
    shadow_d = shadow_q;
    h_write  = 1'b0;
    h_idx    = '0;
    h_data   = '0;
    f_start  = 1'b0;
    done     = 1'b0;
`ifdef FSEQ_WATCHDOG_EN
    err_d    = err_q;
    wd_d     = wd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (hcfg_we && (hcfg_idx < NCOEF_I)) begin
          shadow_d[hcfg_idx] = hcfg_data;
        end
        if (go) begin
          state_d  = S_LOAD;
          k_d      = '0;
          frames_d = (nframes == '0) ? FRAME_W'(1) : nframes;
`ifdef FSEQ_WATCHDOG_EN
          err_d    = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        h_write = 1'b1;
        h_idx   = k_q;
        h_data  = shadow_q[k_q];
        k_d     = k_q + 1'b1;
        if (k_q == LAST_IDX) begin
          state_d = S_START;
          // Engine owns the buffer from the very cycle f_start is seen.
          owner_d = OWN_ENG;
        end
      end
      S_START: begin
        f_start = 1'b1;
        state_d = S_RUN;
`ifdef FSEQ_WATCHDOG_EN
        wd_d    = '0;
`endif
      end
      S_RUN: begin
        if (f_finish) begin
          state_d = S_NEXT;
`ifdef FSEQ_WATCHDOG_EN
        end else if (wd_q == '1) begin
          // Engine hung: give the buffer back and end the job with an error.
          state_d = S_IDLE;
          owner_d = OWN_HOST;
          err_d   = 1'b1;
          done    = 1'b1;
        end else begin
          wd_d    = wd_q + 1'b1;
`endif
        end
      end
      S_NEXT: begin
        frames_d = frames_q - 1'b1;
        if (frames_d != '0) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
          owner_d = OWN_HOST;
          done    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_HOST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_HOST;
      k_q      <= '0;
      frames_q <= '0;
      for (int i = 0; i < NCOEF; i++) begin
        shadow_q[i] <= '0;
      end
`ifdef FSEQ_WATCHDOG_EN
      err_q    <= 1'b0;
      wd_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      k_q      <= k_d;
      frames_q <= frames_d;
      shadow_q <= shadow_d;
`ifdef FSEQ_WATCHDOG_EN
      err_q    <= err_d;
      wd_q     <= wd_d;
`endif
    end
  end

endmodule

// File: tb/tb_filter2d_seq.sv
module tb_filter2d_seq;
  localparam int NCOEF   = 9;
  localparam int IDXW    = 4;
  localparam int DW      = 8;
  localparam int AW      = 17;
  localparam int FRAME_W = 8;
  localparam int TO_W    = 8;

  logic               clk, rst;
  logic               hcfg_we, go;
  logic [IDXW-1:0]    hcfg_idx;
  logic [DW-1:0]      hcfg_data;
  logic [FRAME_W-1:0] nframes;
  logic               busy, done, err;
  logic               hm_cs, hm_we;
  logic [AW-1:0]      hm_addr;
  logic [DW-1:0]      hm_wdata, hm_rdata;
  logic               h_write;
  logic [IDXW-1:0]    h_idx;
  logic [DW-1:0]      h_data;
  logic               f_start, f_finish;
  logic               f_cs, f_we;
  logic [AW-1:0]      f_addr;
  logic [DW-1:0]      f_wdata, f_rdata;
  logic               m_cs, m_we;
  logic [AW-1:0]      m_addr;
  logic [DW-1:0]      m_din, m_dout;

  filter2d_seq #(
    .NCOEF(NCOEF), .IDXW(IDXW), .DW(DW), .AW(AW), .FRAME_W(FRAME_W), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rst(rst),
    .hcfg_we(hcfg_we), .hcfg_idx(hcfg_idx), .hcfg_data(hcfg_data),
    .go(go), .nframes(nframes), .busy(busy), .done(done), .err(err),
    .hm_cs(hm_cs), .hm_we(hm_we), .hm_addr(hm_addr), .hm_wdata(hm_wdata), .hm_rdata(hm_rdata),
    .h_write(h_write), .h_idx(h_idx), .h_data(h_data),
    .f_start(f_start), .f_finish(f_finish),
    .f_cs(f_cs), .f_we(f_we), .f_addr(f_addr), .f_wdata(f_wdata), .f_rdata(f_rdata),
    .m_cs(m_cs), .m_we(m_we), .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port buffer model with one-cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (m_cs && m_we) mem[m_addr] <= m_din;
    if (m_cs && !m_we) m_dout <= mem[m_addr];
  end

  typedef struct packed {
    logic [IDXW-1:0] idx;
    logic [DW-1:0]   data;
  } coef_t;

  coef_t         exp_q[$];
  logic [DW-1:0] shadow_m [NCOEF];

  int checks = 0, failures = 0;
  int ncyc = 0, go_ncyc = 0, fin_ncyc = 0, done_ncyc = 0, last_fstart = 0;
  int fstart_job = 0, done_cnt = 0, done_base = 0, busy_drop = 0, eng_cnt = 0;
  bit in_job = 0, eng_en = 1, expect_timeout = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  // Monitor, scoreboard and filter2d engine model, all on the falling edge.
  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      eng_cnt  = 0;
      f_finish = 1'b0;
    end else begin
      if (h_write) begin
        check("replay_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          coef_t e;
          e = exp_q.pop_front();
          check("replay_idx", h_idx, e.idx);
          check("replay_data", h_data, e.data);
        end
      end
      f_finish = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          f_finish = 1'b1;
          fin_ncyc = ncyc;
        end
      end
      if (f_start) begin
        if (fstart_job == 0) check("go_to_fstart", ncyc - go_ncyc, NCOEF + 1);
        fstart_job++;
        last_fstart = ncyc;
        if (eng_en) eng_cnt = 100;
      end
      if (done) begin
        done_cnt++;
        done_ncyc = ncyc;
        if (!expect_timeout) check("finish_to_done", ncyc - fin_ncyc, 1);
        in_job = 0;
      end
      if (in_job && !busy) busy_drop++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_coef(input logic [IDXW-1:0] idx, input logic [DW-1:0] data);
    hcfg_we = 1'b1; hcfg_idx = idx; hcfg_data = data;
    tick();
    hcfg_we = 1'b0;
  endtask

  task automatic host_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    hm_cs = 1'b1; hm_we = 1'b1; hm_addr = addr; hm_wdata = data;
    tick();
    hm_cs = 1'b0; hm_we = 1'b0;
  endtask

  task automatic host_read(input logic [AW-1:0] addr, output logic [DW-1:0] data);
    hm_cs = 1'b1; hm_we = 1'b0; hm_addr = addr;
    tick();
    data = hm_rdata;
    hm_cs = 1'b0;
  endtask

  task automatic run_job(input logic [FRAME_W-1:0] nf);
    go = 1'b1; nframes = nf;
    for (int k = 0; k < NCOEF; k++) exp_q.push_back({IDXW'(k), shadow_m[k]});
    done_base  = done_cnt;
    fstart_job = 0;
    tick();
    go = 1'b0;
    go_ncyc = ncyc;
    in_job = 1;
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    while (done_cnt == done_base && n < maxc) begin
      tick();
      n++;
    end
    check("job_done_seen", done_cnt - done_base, 1);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } mem_vec_t;

  typedef struct {
    logic [IDXW-1:0] idx;
    logic [DW-1:0]   data;
    logic            accept;
  } coef_vec_t;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    mem_vec_t  mv [7];
    coef_vec_t cv [11];
    logic [DW-1:0] rd;
    int waitn;

    mv[0] = '{1'b1, 17'h00010, 8'h5A, 8'h00};
    mv[1] = '{1'b0, 17'h00010, 8'h00, 8'h5A};
    mv[2] = '{1'b1, 17'h1FFFF, 8'hC3, 8'h00};
    mv[3] = '{1'b0, 17'h1FFFF, 8'h00, 8'hC3};
    mv[4] = '{1'b0, 17'h00011, 8'h00, 8'h00};
    mv[5] = '{1'b1, 17'h00010, 8'h3C, 8'h00};
    mv[6] = '{1'b0, 17'h00010, 8'h00, 8'h3C};

    cv[0]  = '{4'd0, 8'd1, 1'b1};
    cv[1]  = '{4'd1, 8'd2, 1'b1};
    cv[2]  = '{4'd2, 8'd1, 1'b1};
    cv[3]  = '{4'd3, 8'd2, 1'b1};
    cv[4]  = '{4'd4, 8'd4, 1'b1};
    cv[5]  = '{4'd5, 8'd2, 1'b1};
    cv[6]  = '{4'd6, 8'd1, 1'b1};
    cv[7]  = '{4'd7, 8'd2, 1'b1};
    cv[8]  = '{4'd8, 8'd1, 1'b1};
    cv[9]  = '{4'd9, 8'hFF, 1'b0};
    cv[10] = '{4'd15, 8'hEE, 1'b0};

    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    for (int k = 0; k < NCOEF; k++) shadow_m[k] = '0;
    rst = 1'b1; hcfg_we = 0; hcfg_idx = '0; hcfg_data = '0; go = 0; nframes = '0;
    hm_cs = 0; hm_we = 0; hm_addr = '0; hm_wdata = '0; f_finish = 0;
    f_cs = 0; f_we = 0; f_addr = '0; f_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_h_write", h_write, 0);
    check("rst_h_idx", h_idx, 0);
    check("rst_h_data", h_data, 0);
    check("rst_f_start", f_start, 0);
    check("rst_f_rdata", f_rdata, 0);
    check("rst_m_cs", m_cs, 0);

    for (int i = 0; i < 7; i++) begin
      if (mv[i].we) host_write(mv[i].addr, mv[i].wdata);
      else begin
        host_read(mv[i].addr, rd);
        check("host_mem_rd", rd, mv[i].exp_rdata);
      end
    end

    for (int i = 0; i < 11; i++) begin
      set_coef(cv[i].idx, cv[i].data);
      if (cv[i].accept) shadow_m[cv[i].idx] = cv[i].data;
    end

    // Single-frame replay.
    run_job(8'd1);
    wait_done(400);
    check("single_fstarts", fstart_job, 1);
    check("replay_drained", exp_q.size(), 0);
    check("idle_busy", busy, 0);
    check("idle_err", err, 0);

    // Multi-frame: three runs, one done, busy held.
    busy_drop = 0;
    run_job(8'd3);
    wait_done(1000);
    repeat (5) tick();
    check("multi_fstarts", fstart_job, 3);
    check("multi_single_done", done_cnt - done_base, 1);
    check("multi_busy_held", busy_drop, 0);

    // Arbitration: host write during RUN must not land.
    run_job(8'd1);
    waitn = 0;
    while (fstart_job == 0 && waitn < 50) begin tick(); waitn++; end
    check("arb_fstart_seen", fstart_job, 1);
    tick();
    host_write(17'h10000, 8'hAA);
    host_read(17'h10000, rd);
    check("arb_hm_rdata_eng", rd, 0);
    check("arb_mem_protected", mem[17'h10000], 0);
    wait_done(400);
    check("arb_f_rdata_idle", f_rdata, 0);
    host_write(17'h10000, 8'hAA);
    host_read(17'h10000, rd);
    check("arb_idle_write", rd, 8'hAA);

    // go while busy and hcfg_we during LOAD are both dropped; nframes=0 runs once.
    set_coef(4'd4, 8'h09);
    shadow_m[4] = 8'h09;
    run_job(8'd1);
    go = 1'b1; nframes = 8'd5;
    hcfg_we = 1'b1; hcfg_idx = 4'd0; hcfg_data = 8'h77;
    tick();
    go = 1'b0; hcfg_we = 1'b0;
    wait_done(400);
    check("busy_go_ignored", fstart_job, 1);
    run_job(8'd0);
    wait_done(400);
    check("nframes0_one_run", fstart_job, 1);
    check("nframes0_drained", exp_q.size(), 0);

`ifdef FSEQ_WATCHDOG_EN
    eng_en = 0;
    expect_timeout = 1;
    run_job(8'd1);
    wait_done(600);
    check("wd_err_set", err, 1);
    check("wd_busy_clear", busy, 0);
    check("wd_latency", (done_ncyc - last_fstart >= 256) && (done_ncyc - last_fstart <= 258), 1);
    host_read(17'h00010, rd);
    check("wd_owner_host", rd, 8'h3C);
    eng_en = 1;
    expect_timeout = 0;
    run_job(8'd1);
    check("wd_err_cleared", err, 0);
    wait_done(400);
`endif

    // Mid-job reset aborts; engine is not restarted; shadow cleared.
    run_job(8'd2);
    tick();
    tick();
    in_job = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    for (int k = 0; k < NCOEF; k++) shadow_m[k] = '0;
    check("abort_busy", busy, 0);
    check("abort_h_write", h_write, 0);
    fstart_job = 0;
    repeat (30) tick();
    check("abort_no_restart", fstart_job, 0);
    run_job(8'd1);
    wait_done(400);
    check("post_rst_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
